apb2axi_bridge: RTL



---
 rtl/apb2axi_pkg.sv | 33 +++
 rtl/apb2axi_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/apb2axi_pkg.sv
// rtl/apb2axi_pkg.sv - shared types, AXI constants and width helpers for the APB-to-AXI bridge
package apb2axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AXI size encoding for a beat of data_width bits
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

    function automatic int lane_lsb(input int apb_data_width);
        return $clog2(apb_data_width / 8);
    endfunction

    function automatic int lane_msb(input int axi_data_width);
        return $clog2(axi_data_width / 8) - 1;
    endfunction

endpackage

// File: rtl/apb2axi_bridge.sv
// rtl/apb2axi_bridge.sv - APB3 slave to single-beat AXI4 master bridge with lane steering
module apb2axi_bridge
    import apb2axi_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        psel_i,
    input  logic                        penable_i,
    input  logic                        pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]   paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]   pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]   prdata_o,
    output logic                        pready_o,
    output logic                        pslverr_o,

    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
    output logic [7:0]                  aw_len_o,
    output logic [2:0]                  aw_size_o,
    output logic [1:0]                  aw_burst_o,
    output logic                        aw_lock_o,
    output logic [3:0]                  aw_cache_o,
    output logic [2:0]                  aw_prot_o,
    output logic [3:0]                  aw_qos_o,
    output logic [3:0]                  aw_region_o,
    output logic [AXI_USER_WIDTH-1:0]   aw_user_o,

    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
    output logic                        w_last_o,
    output logic [AXI_USER_WIDTH-1:0]   w_user_o,

    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    input  logic [1:0]                  b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   b_user_i,

    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
    output logic [7:0]                  ar_len_o,
    output logic [2:0]                  ar_size_o,
    output logic [1:0]                  ar_burst_o,
    output logic                        ar_lock_o,
    output logic [3:0]                  ar_cache_o,
    output logic [2:0]                  ar_prot_o,
    output logic [3:0]                  ar_qos_o,
    output logic [3:0]                  ar_region_o,
    output logic [AXI_USER_WIDTH-1:0]   ar_user_o,

    input  logic                        r_valid_i,
    output logic                        r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]                  r_resp_i,
    input  logic                        r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]     r_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   r_user_i
);

    localparam int RATIO     = AXI_DATA_WIDTH / APB_DATA_WIDTH;
    localparam int LANE_BITS = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int APB_STRB  = APB_DATA_WIDTH / 8;
    localparam int LANE_LSB  = lane_lsb(APB_DATA_WIDTH);
    localparam int LANE_MSB  = lane_msb(AXI_DATA_WIDTH);

    state_e                      state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q;
    logic [APB_DATA_WIDTH-1:0]   pwdata_q;
    logic                        aw_done_q, w_done_q;
    logic                        pslverr_q;
    logic [APB_DATA_WIDTH-1:0]   prdata_q;
    logic [LANE_BITS-1:0]        lane;

    logic apb_access, aw_fire, w_fire, b_err, r_err;

    // Only one transaction is ever in flight, so IDs and user sidebands carry no information
    logic unused_inputs;
    assign unused_inputs = ^{b_id_i, b_user_i, r_id_i, r_user_i};

    assign apb_access = psel_i && penable_i;
    assign aw_fire    = aw_valid_o && aw_ready_i;
    assign w_fire     = w_valid_o && w_ready_i;
    assign b_err      = (b_resp_i == RESP_SLVERR) || (b_resp_i == RESP_DECERR);
    assign r_err      = (r_resp_i == RESP_SLVERR) || (r_resp_i == RESP_DECERR) || !r_last_i;

    generate
        if (RATIO > 1) begin : g_lane
            assign lane = paddr_q[LANE_MSB:LANE_LSB];
        end else begin : g_single_lane
            assign lane = '0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (apb_access) state_d = pwrite_i ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WR_RESP;
            WR_RESP: if (b_valid_i) state_d = DONE;
            RD_REQ:  if (ar_ready_i) state_d = RD_RESP;
            RD_RESP: if (r_valid_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_q   <= '0;
            pwdata_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    if (apb_access) begin
                        paddr_q  <= paddr_i;
                        pwdata_q <= pwdata_i;
                    end
                end
                WR_REQ: begin
                    if (aw_fire) aw_done_q <= 1'b1;
                    if (w_fire)  w_done_q  <= 1'b1;
                end
                WR_RESP: if (b_valid_i) pslverr_q <= b_err;
                RD_RESP: begin
                    if (r_valid_i) begin
                        pslverr_q <= r_err;
                        prdata_q  <= r_data_i[int'(lane)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign pready_o   = (state_q == DONE);
    assign pslverr_o  = (state_q == DONE) && pslverr_q;
    assign prdata_o   = prdata_q;

    assign aw_valid_o = (state_q == WR_REQ) && !aw_done_q;
    assign w_valid_o  = (state_q == WR_REQ) && !w_done_q;
    assign b_ready_o  = (state_q == WR_RESP);
    assign ar_valid_o = (state_q == RD_REQ);
    assign r_ready_o  = (state_q == RD_RESP);

    assign aw_addr_o   = AXI_ADDR_WIDTH'(paddr_q);
    assign aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
    assign aw_len_o    = 8'd0;
    assign aw_size_o   = axi_size(APB_DATA_WIDTH);
    assign aw_burst_o  = BURST_INCR;
    assign aw_lock_o   = 1'b0;
    assign aw_cache_o  = 4'd0;
    assign aw_prot_o   = 3'd0;
    assign aw_qos_o    = 4'd0;
    assign aw_region_o = 4'd0;
    assign aw_user_o   = '0;

    assign ar_addr_o   = AXI_ADDR_WIDTH'(paddr_q);
    assign ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
    assign ar_len_o    = 8'd0;
    assign ar_size_o   = axi_size(APB_DATA_WIDTH);
    assign ar_burst_o  = BURST_INCR;
    assign ar_lock_o   = 1'b0;
    assign ar_cache_o  = 4'd0;
    assign ar_prot_o   = 3'd0;
    assign ar_qos_o    = 4'd0;
    assign ar_region_o = 4'd0;
    assign ar_user_o   = '0;

    // Write data is replicated on every lane; the strobe picks the lane the address targets
    assign w_data_o = {RATIO{pwdata_q}};
    assign w_last_o = 1'b1;
    assign w_user_o = '0;

    always_comb begin
        w_strb_o = '0;
        w_strb_o[int'(lane)*APB_STRB +: APB_STRB] = '1;
    end

endmodule
